// File: rtl/id_stage_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU op codes, control bundle and
// immediate-format helpers used by the decode stage and its testbench.
package id_stage_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_op_e;

    // Field order fixes the ex_ctrl bit positions (reg_write is bit 8).
    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic jal;
        logic jalr;
        logic alu_src;
        logic lui;
        logic auipc;
    } ctrl_t;

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

    function automatic logic [31:0] imm_gen(input logic [31:0] i, input imm_fmt_e fmt);
        case (fmt)
            IMM_I:   return {{20{i[31]}}, i[31:20]};
            IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   return {i[31:12], 12'b0};
            IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return '0;
        endcase
    endfunction

    // alt selects SUB/SRA; callers decide when funct7[5] is meaningful.
    function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// 32-entry register file: two combinational read ports, one write port at the
// clock edge, x0 hardwired to zero, optional same-cycle write-to-read bypass.
module regfile_2r1w #(
    parameter int XLEN      = 32,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] mem [32];

    always_ff @(posedge clk)
        if (we && waddr != 5'd0) mem[waddr] <= wdata;

    always_comb begin
        rdata1 = mem[raddr1];
        if (WB_BYPASS && we && waddr == raddr1) rdata1 = wdata;
        if (raddr1 == 5'd0) rdata1 = '0;
    end

    always_comb begin
        rdata2 = mem[raddr2];
        if (WB_BYPASS && we && waddr == raddr2) rdata2 = wdata;
        if (raddr2 == 5'd0) rdata2 = '0;
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: IF/ID register, register file, immediate generator,
// control decoder, load-use hazard detection and the ID/EX register.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [31:0]     if_pc,
    input  logic [31:0]     if_instr,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            stall,
    output logic            ex_valid,
    output logic [31:0]     ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_funct3,
    output logic [3:0]      ex_alu_op,
    output logic [8:0]      ex_ctrl,
    output logic            ex_illegal
);

    // vld_pipe[0]: IF/ID holds a real instruction, vld_pipe[1]: ID/EX does.
    logic [1:0]  vld_pipe;
    logic [31:0] id_instr, id_pc;
    ctrl_t       ex_ctrl_q;
    alu_op_e     ex_alu_q;

    logic [6:0] opcode;
    logic [4:0] rs1, rs2, rd;
    logic [2:0] funct3;
    assign opcode = id_instr[6:0];
    assign rd     = id_instr[11:7];
    assign funct3 = id_instr[14:12];
    assign rs1    = id_instr[19:15];
    assign rs2    = id_instr[24:20];

    logic [XLEN-1:0] rs1_data, rs2_data;

    regfile_2r1w #(.XLEN(XLEN), .WB_BYPASS(WB_BYPASS)) u_rf (
        .clk    (clk),
        .we     (wb_we),
        .waddr  (wb_rd),
        .wdata  (wb_data),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data)
    );

    ctrl_t    ctrl_d;
    alu_op_e  alu_d;
    imm_fmt_e fmt;
    logic     illegal_d, uses_rs1, uses_rs2;

    always_comb begin
        ctrl_d    = '0;
        alu_d     = ALU_ADD;
        fmt       = IMM_NONE;
        illegal_d = 1'b0;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b0;
        case (opcode)
            OPC_LUI: begin
                ctrl_d.reg_write = 1'b1; ctrl_d.alu_src = 1'b1; ctrl_d.lui = 1'b1;
                alu_d = ALU_PASSB; fmt = IMM_U; uses_rs1 = 1'b0;
            end
            OPC_AUIPC: begin
                ctrl_d.reg_write = 1'b1; ctrl_d.alu_src = 1'b1; ctrl_d.auipc = 1'b1;
                fmt = IMM_U; uses_rs1 = 1'b0;
            end
            OPC_JAL: begin
                ctrl_d.reg_write = 1'b1; ctrl_d.jal = 1'b1;
                fmt = IMM_J; uses_rs1 = 1'b0;
            end
            OPC_JALR: begin
                ctrl_d.reg_write = 1'b1; ctrl_d.jalr = 1'b1; ctrl_d.alu_src = 1'b1;
                fmt = IMM_I;
            end
            OPC_BRANCH: begin
                ctrl_d.branch = 1'b1; alu_d = ALU_SUB; fmt = IMM_B; uses_rs2 = 1'b1;
            end
            OPC_LOAD: begin
                ctrl_d.reg_write = 1'b1; ctrl_d.mem_read = 1'b1; ctrl_d.alu_src = 1'b1;
                fmt = IMM_I;
            end
            OPC_STORE: begin
                ctrl_d.mem_write = 1'b1; ctrl_d.alu_src = 1'b1;
                fmt = IMM_S; uses_rs2 = 1'b1;
            end
            OPC_OPIMM: begin
                // Only SRAI looks at funct7[5]; ADDI never becomes SUB.
                ctrl_d.reg_write = 1'b1; ctrl_d.alu_src = 1'b1; fmt = IMM_I;
                alu_d = alu_decode(funct3, funct3 == 3'b101 && id_instr[30]);
            end
            OPC_OP: begin
                ctrl_d.reg_write = 1'b1; uses_rs2 = 1'b1;
                alu_d = alu_decode(funct3, id_instr[30]);
            end
            default: illegal_d = 1'b1;
        endcase
    end

    assign stall = vld_pipe[1] & ex_ctrl_q.mem_read & (ex_rd != 5'd0) & ~flush &
                   ((uses_rs1 & (rs1 == ex_rd)) | (uses_rs2 & (rs2 == ex_rd)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe    <= '0;
            id_instr    <= NOP_INSTR;
            id_pc       <= '0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_funct3   <= '0;
            ex_alu_q    <= ALU_ADD;
            ex_ctrl_q   <= '0;
            ex_illegal  <= 1'b0;
        end else begin
            if (flush) begin
                id_instr    <= NOP_INSTR;
                vld_pipe[0] <= 1'b0;
            end else if (!stall) begin
                id_instr    <= if_instr;
                id_pc       <= if_pc;
                vld_pipe[0] <= 1'b1;
            end

            if (flush || stall) begin
                vld_pipe[1] <= 1'b0;
                ex_ctrl_q   <= '0;
                ex_illegal  <= 1'b0;
            end else begin
                vld_pipe[1] <= vld_pipe[0];
                ex_ctrl_q   <= vld_pipe[0] ? ctrl_d : '0;
                ex_illegal  <= vld_pipe[0] & illegal_d;
                ex_pc       <= id_pc;
                ex_rs1_data <= rs1_data;
                ex_rs2_data <= rs2_data;
                ex_imm      <= XLEN'($signed(imm_gen(id_instr, fmt)));
                ex_rs1      <= rs1;
                ex_rs2      <= rs2;
                ex_rd       <= rd;
                ex_funct3   <= funct3;
                ex_alu_q    <= alu_d;
            end
        end
    end

    assign ex_valid  = vld_pipe[1];
    assign ex_ctrl   = ex_ctrl_q;
    assign ex_alu_op = ex_alu_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed testbench for id_stage: reset, load-use stall, WB bypass,
// flush priority, immediate formats, illegal opcode and mid-run reset.
module tb_id_stage;
    import id_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n, flush, wb_we;
    logic [31:0] if_pc, if_instr, wb_data;
    logic [4:0]  wb_rd;
    logic        stall, ex_valid, ex_illegal;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_funct3;
    logic [3:0]  ex_alu_op;
    logic [8:0]  ex_ctrl;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    id_stage #(.XLEN(32), .WB_BYPASS(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .if_pc(if_pc), .if_instr(if_instr),
        .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
        .ex_alu_op(ex_alu_op), .ex_ctrl(ex_ctrl), .ex_illegal(ex_illegal)
    );

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OPC_OP};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [31:0] pc, input logic [31:0] instr);
        if_pc    = pc;
        if_instr = instr;
    endtask

    logic [31:0] tbl_instr [7];
    logic [31:0] tbl_imm   [7];
    logic [8:0]  tbl_ctrl  [7];
    logic [3:0]  tbl_alu   [7];

    task automatic chk_tbl(input int k);
        chk($sformatf("imm_%0d", k), ex_imm, tbl_imm[k]);
        chk($sformatf("ctrl_%0d", k), {23'd0, ex_ctrl}, {23'd0, tbl_ctrl[k]});
        chk($sformatf("alu_%0d", k), {28'd0, ex_alu_op}, {28'd0, tbl_alu[k]});
        chk($sformatf("valid_%0d", k), {31'd0, ex_valid}, 32'd1);
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        feed(32'h0, NOP_INSTR);

        // Reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_ctrl", {23'd0, ex_ctrl}, 32'd0);
        chk("rst_alu", {28'd0, ex_alu_op}, 32'd0);
        chk("rst_pc", ex_pc, 32'd0);
        reset_n = 1'b1;

        feed(32'h100, enc_i(12'd5, 5'd0, 3'b000, 5'd1, OPC_OPIMM));
        tick;
        chk("first_bubble", {31'd0, ex_valid}, 32'd0);
        feed(32'h104, NOP_INSTR);
        tick;
        chk("addi_valid", {31'd0, ex_valid}, 32'd1);
        chk("addi_imm", ex_imm, 32'd5);
        chk("addi_rd", {27'd0, ex_rd}, 32'd1);
        chk("addi_ctrl", {23'd0, ex_ctrl}, 32'h104);
        chk("addi_pc", ex_pc, 32'h100);

        // Load-use: LW x5,0(x2) ; ADD x6,x5,x7
        feed(32'h200, enc_i(12'd0, 5'd2, 3'b010, 5'd5, OPC_LOAD));
        tick;
        feed(32'h204, enc_r(7'd0, 5'd7, 5'd5, 3'b000, 5'd6));
        tick;
        chk("lu_lw_ctrl", {23'd0, ex_ctrl}, 32'h184);
        chk("lu_stall", {31'd0, stall}, 32'd1);
        if_pc = 32'hBAD;
        tick;
        chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
        chk("lu_bubble_ctrl", {23'd0, ex_ctrl}, 32'd0);
        chk("lu_stall_once", {31'd0, stall}, 32'd0);
        feed(32'h208, NOP_INSTR);
        tick;
        chk("lu_add_valid", {31'd0, ex_valid}, 32'd1);
        chk("lu_add_rs1", {27'd0, ex_rs1}, 32'd5);
        chk("lu_add_rs2", {27'd0, ex_rs2}, 32'd7);
        chk("lu_add_rd", {27'd0, ex_rd}, 32'd6);
        chk("lu_add_pc", ex_pc, 32'h204);

        // Load into x0 never stalls
        feed(32'h20C, enc_i(12'd0, 5'd2, 3'b010, 5'd0, OPC_LOAD));
        tick;
        feed(32'h210, enc_r(7'd0, 5'd7, 5'd0, 3'b000, 5'd6));
        tick;
        chk("lw0_ctrl", {23'd0, ex_ctrl}, 32'h184);
        chk("lw0_nostall", {31'd0, stall}, 32'd0);
        feed(32'h214, NOP_INSTR);
        tick;
        chk("lw0_issue_valid", {31'd0, ex_valid}, 32'd1);
        chk("lw0_issue_pc", ex_pc, 32'h210);

        // Flush in the same cycle as a load-use stall
        feed(32'h300, enc_i(12'd0, 5'd2, 3'b010, 5'd5, OPC_LOAD));
        tick;
        feed(32'h304, enc_r(7'd0, 5'd7, 5'd5, 3'b000, 5'd6));
        tick;
        chk("fl_stall_pre", {31'd0, stall}, 32'd1);
        flush = 1'b1;
        #1;
        chk("fl_stall_masked", {31'd0, stall}, 32'd0);
        feed(32'h308, enc_i(12'd9, 5'd0, 3'b000, 5'd11, OPC_OPIMM));
        tick;
        flush = 1'b0;
        chk("fl_valid", {31'd0, ex_valid}, 32'd0);
        chk("fl_ctrl", {23'd0, ex_ctrl}, 32'd0);
        feed(32'h400, enc_i(12'd3, 5'd0, 3'b000, 5'd12, OPC_OPIMM));
        tick;
        chk("fl_nop_valid", {31'd0, ex_valid}, 32'd0);
        chk("fl_nop_rd", {27'd0, ex_rd}, 32'd0);
        feed(32'h404, NOP_INSTR);
        tick;
        chk("fl_next_valid", {31'd0, ex_valid}, 32'd1);
        chk("fl_next_rd", {27'd0, ex_rd}, 32'd12);
        chk("fl_next_imm", ex_imm, 32'd3);
        chk("fl_next_pc", ex_pc, 32'h400);

        // WB bypass and x0 write
        feed(32'h500, enc_r(7'd0, 5'd3, 5'd3, 3'b000, 5'd4));
        tick;
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
        feed(32'h504, enc_r(7'd0, 5'd0, 5'd0, 3'b000, 5'd8));
        tick;
        chk("byp_rs1", ex_rs1_data, 32'hDEADBEEF);
        chk("byp_rs2", ex_rs2_data, 32'hDEADBEEF);
        wb_rd = 5'd0; wb_data = 32'hFFFFFFFF;
        feed(32'h508, enc_r(7'd0, 5'd0, 5'd3, 3'b000, 5'd9));
        tick;
        chk("x0_rs1", ex_rs1_data, 32'd0);
        chk("x0_rs2", ex_rs2_data, 32'd0);
        wb_we = 1'b0;
        feed(32'h50C, NOP_INSTR);
        tick;
        chk("rf_x3", ex_rs1_data, 32'hDEADBEEF);
        chk("rf_x0", ex_rs2_data, 32'd0);

        // Immediate formats and decode table
        tbl_instr[0] = enc_b(13'h1FFC, 5'd0, 5'd0, 3'b000);
        tbl_imm[0] = 32'hFFFFFFFC; tbl_ctrl[0] = 9'h020; tbl_alu[0] = 4'd1;
        tbl_instr[1] = enc_j(21'h000800, 5'd0);
        tbl_imm[1] = 32'h00000800; tbl_ctrl[1] = 9'h110; tbl_alu[1] = 4'd0;
        tbl_instr[2] = enc_s(12'hFFF, 5'd0, 5'd0, 3'b010);
        tbl_imm[2] = 32'hFFFFFFFF; tbl_ctrl[2] = 9'h044; tbl_alu[2] = 4'd0;
        tbl_instr[3] = {20'hABCDE, 5'd1, OPC_LUI};
        tbl_imm[3] = 32'hABCDE000; tbl_ctrl[3] = 9'h106; tbl_alu[3] = 4'd10;
        tbl_instr[4] = enc_r(7'b0100000, 5'd3, 5'd2, 3'b000, 5'd1);
        tbl_imm[4] = 32'h0; tbl_ctrl[4] = 9'h100; tbl_alu[4] = 4'd1;
        tbl_instr[5] = enc_i(12'h403, 5'd1, 3'b101, 5'd1, OPC_OPIMM);
        tbl_imm[5] = 32'h00000403; tbl_ctrl[5] = 9'h104; tbl_alu[5] = 4'd7;
        tbl_instr[6] = enc_i(12'hC00, 5'd0, 3'b000, 5'd1, OPC_OPIMM);
        tbl_imm[6] = 32'hFFFFFC00; tbl_ctrl[6] = 9'h104; tbl_alu[6] = 4'd0;
        for (int k = 0; k < 7; k++) begin
            feed(32'h600 + 32'(4 * k), tbl_instr[k]);
            tick;
            if (k > 0) chk_tbl(k - 1);
        end
        feed(32'h700, NOP_INSTR);
        tick;
        chk_tbl(6);

        // Illegal opcode
        feed(32'h710, 32'h0000007F);
        tick;
        feed(32'h714, NOP_INSTR);
        chk("ill_stall_id", {31'd0, stall}, 32'd0);
        tick;
        chk("ill_flag", {31'd0, ex_illegal}, 32'd1);
        chk("ill_ctrl", {23'd0, ex_ctrl}, 32'd0);
        chk("ill_stall", {31'd0, stall}, 32'd0);

        // Reset mid-operation
        feed(32'h800, enc_i(12'd5, 5'd0, 3'b000, 5'd1, OPC_OPIMM));
        tick;
        feed(32'h804, enc_i(12'd6, 5'd0, 3'b000, 5'd2, OPC_OPIMM));
        tick;
        chk("mr_pre_valid", {31'd0, ex_valid}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mr_valid", {31'd0, ex_valid}, 32'd0);
        chk("mr_ctrl", {23'd0, ex_ctrl}, 32'd0);
        chk("mr_pc", ex_pc, 32'd0);
        chk("mr_rd", {27'd0, ex_rd}, 32'd0);
        reset_n = 1'b1;
        feed(32'h900, NOP_INSTR);
        tick;
        chk("mr_bubble", {31'd0, ex_valid}, 32'd0);
        tick;
        chk("mr_resume_valid", {31'd0, ex_valid}, 32'd1);
        chk("mr_resume_pc", ex_pc, 32'h900);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
